// File: rtl/fejkon_sysinfo.sv
// fejkon_sysinfo: Avalon-MM system information slave.
// Identity, git hash, scratch word, optional 64-bit uptime with atomic
// HI snapshot, and per-port link status with sticky link-down flags.
// Optional feature macro: FEJKON_SYSINFO_UPTIME_EN (uptime counter + snapshot).
// FEJKON_GIT_HASH is normally supplied by the build; a fixed default value is used otherwise.

`ifndef FEJKON_GIT_HASH
`define FEJKON_GIT_HASH 32'h1234_ABCD
`endif

module fejkon_sysinfo #(
    parameter int unsigned PORTS   = 1,
    parameter logic [7:0]  VERSION = 8'h02
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       mm_address,
    input  logic             mm_read,
    input  logic             mm_write,
    input  logic [31:0]      mm_writedata,
    output logic [31:0]      mm_readdata,
    output logic             mm_readdatavalid,
    input  logic [PORTS-1:0] port_up
);

    localparam logic [2:0] A_ID     = 3'd0;
    localparam logic [2:0] A_GIT    = 3'd1;
    localparam logic [2:0] A_SCRATCH= 3'd2;
    localparam logic [2:0] A_UPLO   = 3'd3;
    localparam logic [2:0] A_UPHI   = 3'd4;
    localparam logic [2:0] A_STATUS = 3'd5;
    localparam logic [2:0] A_CAPS   = 3'd6;

    logic [31:0]      r_scratch;
    logic [PORTS-1:0] r_port_up;   // sampled port_up, visible in PORT_STATUS
    logic [PORTS-1:0] r_port_q;    // previous sample, for falling-edge detect
    logic [PORTS-1:0] r_down;      // sticky link-down flags

    logic [PORTS-1:0] w_fall;
    logic [PORTS-1:0] w_clr;
    logic [31:0]      w_status;
    logic [31:0]      w_rdata;
    logic             w_caps_uptime;

    assign w_fall = r_port_q & ~r_port_up;
    assign w_clr  = (mm_write && mm_address == A_STATUS) ? mm_writedata[16 +: PORTS] : '0;

`ifdef FEJKON_SYSINFO_UPTIME_EN
    logic [63:0] r_uptime;
    logic [31:0] r_snap_hi;

    // Free-running counter; a LO read captures HI so the pair is coherent.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_uptime  <= '0;
            r_snap_hi <= '0;
        end else begin
            r_uptime <= r_uptime + 64'd1;
            if (mm_read && mm_address == A_UPLO)
                r_snap_hi <= r_uptime[63:32];
        end
    end

    assign w_caps_uptime = 1'b1;
`else
    assign w_caps_uptime = 1'b0;
`endif

    // Scratch register and link status sampling / sticky flags.
    // A set event wins over a same-cycle write-1-clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_scratch <= '0;
            r_port_up <= '0;
            r_port_q  <= '0;
            r_down    <= '0;
        end else begin
            if (mm_write && mm_address == A_SCRATCH)
                r_scratch <= mm_writedata;
            r_port_up <= port_up;
            r_port_q  <= r_port_up;
            r_down    <= (r_down & ~w_clr) | w_fall;
        end
    end

    // PORT_STATUS word: nonexistent port bits stay 0.
    always_comb begin
        w_status              = '0;
        w_status[PORTS-1:0]   = r_port_up;
        w_status[16 +: PORTS] = r_down;
    end

    // Read mux; all sources are registered, so a same-cycle write is not seen.
    always_comb begin
        w_rdata = '0;
        case (mm_address)
            A_ID:      w_rdata = {8'(PORTS), VERSION, 16'h0DE5};
            A_GIT:     w_rdata = `FEJKON_GIT_HASH;
            A_SCRATCH: w_rdata = r_scratch;
`ifdef FEJKON_SYSINFO_UPTIME_EN
            A_UPLO:    w_rdata = r_uptime[31:0];
            A_UPHI:    w_rdata = r_snap_hi;
`endif
            A_STATUS:  w_rdata = w_status;
            A_CAPS:    w_rdata = {31'b0, w_caps_uptime};
            default:   w_rdata = '0;
        endcase
    end

    // Fixed one-cycle read response; reset drops any read in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mm_readdatavalid <= 1'b0;
            mm_readdata      <= '0;
        end else begin
            mm_readdatavalid <= mm_read;
            if (mm_read)
                mm_readdata <= w_rdata;
        end
    end

endmodule

// File: tb/tb_fejkon_sysinfo.sv
// Self-checking bench for fejkon_sysinfo (PORTS=2, VERSION=8'h02).
// Reads push expected data to a scoreboard; the monitor pops on readdatavalid.

`ifndef FEJKON_GIT_HASH
`define FEJKON_GIT_HASH 32'h1234_ABCD
`endif

module tb_fejkon_sysinfo;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  mm_address = '0;
    logic        mm_read = 1'b0;
    logic        mm_write = 1'b0;
    logic [31:0] mm_writedata = '0;
    logic [31:0] mm_readdata;
    logic        mm_readdatavalid;
    logic [1:0]  port_up = 2'b11;

    int n_vec = 0;
    int n_err = 0;
    int cyc_cnt = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];
    int          iss_q[$];

`ifdef FEJKON_SYSINFO_UPTIME_EN
    localparam logic [31:0] CAPS_EXP = 32'h1;
`else
    localparam logic [31:0] CAPS_EXP = 32'h0;
`endif

    fejkon_sysinfo #(.PORTS(2), .VERSION(8'h02)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .mm_address       (mm_address),
        .mm_read          (mm_read),
        .mm_write         (mm_write),
        .mm_writedata     (mm_writedata),
        .mm_readdata      (mm_readdata),
        .mm_readdatavalid (mm_readdatavalid),
        .port_up          (port_up)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: every readdatavalid must match an issued read, one cycle later.
    always @(negedge clk) begin
        if (mm_readdatavalid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_rdv", 64'd1, 64'd0);
            end else begin
                automatic logic [31:0] e = exp_q.pop_front();
                automatic string       t = tag_q.pop_front();
                automatic int          c = iss_q.pop_front();
                chk(t, 64'(mm_readdata), 64'(e));
                chk({t, "_lat"}, 64'(cyc_cnt), 64'(c + 1));
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] e, input string t);
        mm_address = a;
        mm_read    = 1'b1;
        exp_q.push_back(e);
        tag_q.push_back(t);
        iss_q.push_back(cyc_cnt);
        cyc();
        mm_read = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        mm_address   = a;
        mm_write     = 1'b1;
        mm_writedata = d;
        cyc();
        mm_write = 1'b0;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        cyc(3);
        @(negedge clk);
        chk("rst_rdv", 64'(mm_readdatavalid), 64'd0);
        chk("rst_rdata", 64'(mm_readdata), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        cyc(3);

        // Identity and map
        rd(3'd0, 32'h0202_0DE5, "id");
        rd(3'd1, `FEJKON_GIT_HASH, "git");
        rd(3'd2, 32'h0, "scratch_rst");
        rd(3'd5, 32'h0000_0003, "status_init");
        rd(3'd6, CAPS_EXP, "caps");
        rd(3'd7, 32'h0, "rsvd");
`ifndef FEJKON_SYSINFO_UPTIME_EN
        rd(3'd3, 32'h0, "uplo_absent");
        rd(3'd4, 32'h0, "uphi_absent");
`endif

        // Scratch and read-only protection
        wr(3'd2, 32'hA5A5_5A5A);
        rd(3'd2, 32'hA5A5_5A5A, "scratch_wr");
        wr(3'd0, 32'hFFFF_FFFF);
        wr(3'd1, 32'hFFFF_FFFF);
        wr(3'd6, 32'hFFFF_FFFF);
        wr(3'd7, 32'hFFFF_FFFF);
        rd(3'd0, 32'h0202_0DE5, "id_ro");
        rd(3'd1, `FEJKON_GIT_HASH, "git_ro");
        rd(3'd6, CAPS_EXP, "caps_ro");
        rd(3'd7, 32'h0, "rsvd_ro");

        // Simultaneous read+write returns the old value
        mm_address = 3'd2; mm_read = 1'b1; mm_write = 1'b1; mm_writedata = 32'h1357_9BDF;
        exp_q.push_back(32'hA5A5_5A5A); tag_q.push_back("rw_old"); iss_q.push_back(cyc_cnt);
        cyc();
        mm_read = 1'b0; mm_write = 1'b0;
        rd(3'd2, 32'h1357_9BDF, "rw_new");

`ifdef FEJKON_SYSINFO_UPTIME_EN
        // Uptime snapshot: LO at N, HI at N+5
        dut.r_uptime = 64'h0000_0001_FFFF_FFFE;
        rd(3'd3, 32'hFFFF_FFFE, "uplo");
        cyc(4);
        rd(3'd4, 32'h0000_0001, "uphi");
        // LO at N and N+3, snapshot follows the later LO
        dut.r_uptime = 64'h0000_0001_FFFF_FFFE;
        rd(3'd3, 32'hFFFF_FFFE, "uplo2a");
        cyc(2);
        rd(3'd3, 32'h0000_0001, "uplo2b");
        rd(3'd4, 32'h0000_0002, "uphi2");
        // Wrap at 2^64-1
        dut.r_uptime = 64'hFFFF_FFFF_FFFF_FFFF;
        cyc();
        rd(3'd3, 32'h0, "wrap_lo");
        rd(3'd4, 32'h0, "wrap_hi");
`endif

        // Link status: port 1 goes down then up
        port_up = 2'b01; cyc(2);
        port_up = 2'b11; cyc(3);
        rd(3'd5, 32'h0002_0003, "flag_set");
        wr(3'd5, 32'h0000_FFFF);
        rd(3'd5, 32'h0002_0003, "flag_w0");
        wr(3'd5, 32'h0002_0000);
        rd(3'd5, 32'h0000_0003, "flag_clr");
        // Status bit follows port_up through one register stage
        port_up = 2'b10;
        rd(3'd5, 32'h0000_0003, "status_pre");
        rd(3'd5, 32'h0000_0002, "status_n1");
        rd(3'd5, 32'h0001_0002, "flag0_n2");
        port_up = 2'b11; cyc(2);
        wr(3'd5, 32'h0001_0000);
        rd(3'd5, 32'h0000_0003, "flag0_clr");
        // Clear write in the same cycle as a new set event
        port_up = 2'b01; cyc();
        wr(3'd5, 32'h0002_0000);
        port_up = 2'b11; cyc(2);
        rd(3'd5, 32'h0002_0003, "flag_set_wins");

        // Reset with a read in the same cycle drops it and clears state
        wr(3'd2, 32'hCAFE_F00D);
        cyc(2);
        if (exp_q.size() != 0) chk("drain_before_rst", 64'(exp_q.size()), 64'd0);
        mm_address = 3'd2; mm_read = 1'b1; reset_n = 1'b0;
        cyc();
        mm_read = 1'b0;
        @(negedge clk);
        chk("rst_drop_rdv", 64'(mm_readdatavalid), 64'd0);
        chk("rst_drop_rdata", 64'(mm_readdata), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        cyc(3);
        rd(3'd2, 32'h0, "scratch_after_rst");
        rd(3'd5, 32'h0000_0003, "status_after_rst");
`ifdef FEJKON_SYSINFO_UPTIME_EN
        rd(3'd4, 32'h0, "uphi_after_rst");
`endif

        cyc(4);
        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
